// File: rtl/ef_adc_ahbl_drain.sv
// AHB-Lite initiator that copies words from the ADC DATA register into a
// circular word buffer, one non-pipelined read-then-write pair per word.
module ef_adc_ahbl_drain #(
  parameter int BUF_WORDS = 16,
  parameter int CNT_W     = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_base,
  input  logic [CNT_W-1:0] count,
  input  logic             start,
  input  logic             auto_en,
  input  logic             trig,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_done,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  localparam int         OFF_W        = $clog2(4 * BUF_WORDS);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_D, FIN} state_t;

  state_t           state, state_nx;
  logic             trig_q;
  logic             accept;
  logic             in_data;
  logic             data_ok;
  logic             data_err;
  logic             last_word;
  logic [CNT_W:0]   wd_next;
  logic [31:0]      src_q;
  logic [31:0]      base_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OFF_W-1:0] off_q;

  // A trig edge is only seen against the previous cycle, so edges that land
  // while a burst is running are lost rather than queued.
  assign accept    = (state == IDLE) && (start || (auto_en && trig && !trig_q));
  assign in_data   = (state == RD_D) || (state == WR_D);
  assign data_ok   = in_data && HREADY && !HRESP;
  assign data_err  = in_data && HREADY && HRESP;
  assign wd_next   = {1'b0, words_done} + (CNT_W+1)'(1);
  assign last_word = !(wd_next < {1'b0, cnt_q});
  assign HSIZE     = 3'b010;

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (count == '0) ? FIN : RD_A;
      RD_A: if (HREADY) state_nx = RD_D;
      RD_D: if (HREADY) state_nx = HRESP ? FIN : WR_A;
      WR_A: if (HREADY) state_nx = WR_D;
      WR_D: if (HREADY) state_nx = (HRESP || last_word) ? FIN : RD_A;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      trig_q <= 1'b0;
    end else begin
      state  <= state_nx;
      trig_q <= trig;
    end
  end

  // Bus outputs are registered from the next state so the address phase
  // starts on the cycle after the decision, with no combinational paths out.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR      <= '0;
      HTRANS     <= TRANS_IDLE;
      HWRITE     <= 1'b0;
      HWDATA     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      words_done <= '0;
      src_q      <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      off_q      <= '0;
    end else begin
      HTRANS <= (state_nx == RD_A || state_nx == WR_A) ? TRANS_NONSEQ : TRANS_IDLE;
      HWRITE <= (state_nx == WR_A || state_nx == WR_D);
      busy   <= (state_nx != IDLE);
      done   <= (state_nx == FIN);

      if (state_nx == RD_A)      HADDR <= accept ? src_addr : src_q;
      else if (state_nx == WR_A) HADDR <= base_q + 32'(off_q);

      if (accept) begin
        src_q      <= src_addr;
        base_q     <= dst_base;
        cnt_q      <= count;
        words_done <= '0;
        error      <= 1'b0;
        // The ring position survives across bursts into the same buffer.
        if (dst_base != base_q) off_q <= '0;
      end

      if (data_ok && state == RD_D) HWDATA <= HRDATA;
      if (data_ok && state == WR_D) begin
        words_done <= wd_next[CNT_W-1:0];
        off_q      <= off_q + OFF_W'(4);
      end
      if (data_err) error <= 1'b1;
    end
  end

endmodule

// File: doc/ef_adc_ahbl_drain.md
# ef_adc_ahbl_drain

AHB-Lite initiator that drains conversion results from the ADC controller's DATA register (a fixed source address) into a circular word buffer in system memory. It sits beside the CPU on the AHB-Lite bus: the ADC controller's `irq` (or a software start) triggers a burst of `count` read-then-write word transfers. This offloads the CPU from the FIFO-read loop that software otherwise runs on every FIFO-level interrupt.

## Interface
Parameters:
- `BUF_WORDS`, 16: destination ring size in 32-bit words (power of two, 2..1024).
- `CNT_W`, 8: width of `count` and `words_done`.

Ports:
- `HCLK` in 1: the single clock; all logic is on its rising edge.
- `HRESETn` in 1: reset, asynchronous and active-low.
- `src_addr` in 32: source (ADC DATA register) address; word aligned; sampled at start.
- `dst_base` in 32: ring base address; aligned to `4*BUF_WORDS`; sampled at start.
- `count` in CNT_W: words per burst; sampled at start.
- `start` in 1: one-cycle software start pulse.
- `auto_en` in 1: when 1, a rising edge of `trig` acts as `start`.
- `trig` in 1: level trigger, typically the ADC controller `irq`.
- `busy` out 1: high from the accepted start until `done`.
- `done` out 1: one-cycle pulse at the end of a burst.
- `error` out 1: sticky; set on HRESP error; cleared by the next accepted start.
- `words_done` out CNT_W: words completed in the current or last burst.
- `HADDR` out 32, `HTRANS` out 2, `HSIZE` out 3, `HWRITE` out 1, `HWDATA` out 32: AHB-Lite initiator outputs.
- `HRDATA` in 32, `HREADY` in 1, `HRESP` in 1: AHB-Lite responder inputs.

## Operation
- States are IDLE, RD_A, RD_D, WR_A, WR_D and FIN.
- **IDLE**
  - `start`, or `auto_en & trig` rising, is accepted.
  - On acceptance: latch `src_addr`, `dst_base` and `count`; clear `words_done` and `error`; set `busy`.
  - `count==0` goes to FIN; otherwise go to RD_A.
- **RD_A**: drive HADDR=src, HTRANS=NONSEQ(2'b10), HWRITE=0. Hold until `HREADY`=1, then go to RD_D.
- **RD_D**: HTRANS=IDLE. When `HREADY`=1: latch `HRDATA` into `HWDATA` and go to WR_A.
- **WR_A**: drive HADDR=dst pointer, HTRANS=NONSEQ, HWRITE=1. Advance to WR_D on `HREADY`.
- **WR_D**: HTRANS=IDLE, `HWDATA` held. When `HREADY`=1:
  - increment `words_done`;
  - advance the dst pointer by 4, wrapping: offset = (offset+4) mod 4*BUF_WORDS;
  - go to RD_A if `words_done+1 < count`, else go to FIN.
- **FIN**: pulse `done`, clear `busy`, go to IDLE.
- The dst pointer persists across bursts. It resets to offset 0 only on reset, or when a start presents a `dst_base` different from the latched one.
- Transfers are non-pipelined: there is never an address phase overlapping a data phase. HSIZE is always 3'b010.
- **Error handling**
  - `HRESP`=1 in RD_D or WR_D: on the first error cycle (`HREADY`=0), HTRANS stays IDLE. On the second (`HREADY`=1), set `error` and go to FIN.
  - A failed read is not written. A failed write is not counted.
- **Ignored inputs**
  - `start`/`trig` while `busy` are ignored. A `trig` edge during `busy` is not queued.
  - `trig` held high after a burst does not retrigger; a new rising edge is required.
- **Reset**
  - Reset mid-burst asynchronously forces IDLE, HTRANS=IDLE and `busy`=0, abandoning any in-flight transfer.
  - Reset values: HADDR=0, HTRANS=0, HSIZE=3'b010, HWRITE=0, HWDATA=0, `busy`=0, `done`=0, `error`=0, `words_done`=0, dst offset=0.

## Timing
- All outputs are registered.
- Start to first NONSEQ on HTRANS: 1 cycle.
- Zero-wait-state bus: 4 HCLK per word (RD_A, RD_D, WR_A, WR_D).
  - `done` asserts in the cycle after the last WR_D with `HREADY`=1.
  - Burst length = 4*count+2 cycles from start to `done` inclusive.
- Each responder wait state adds exactly one cycle. Address and control are held stable while `HREADY`=0.
- The `trig` edge detector compares against the previous-cycle value. With `auto_en`=1, acceptance happens 1 cycle after `trig` rises.
- `count==0`: `done` pulses 1 cycle after start, with no bus activity.

## Test plan
- **Single burst**: `src_addr`=0x0018, `dst_base`=0x2000_0000, `count`=5, responder returns 0x101..0x105 with zero waits, `start` pulse.
  - Writes of 0x101..0x105 go to 0x2000_0000..0x2000_0010.
  - `done` comes 22 cycles after start; `words_done`=5; `error`=0.
- **Ring wrap**: `BUF_WORDS`=4, two bursts of `count`=3.
  - Write addresses are base+0, 4, 8, then base+0xC, 0x0, 0x4.
- **Wait states**: responder inserts 2 waits on every data phase, `count`=2.
  - HADDR and HTRANS are stable during waits; `done` comes 18 cycles after start.
- **Error response**: error on the 2nd read of `count`=4.
  - Exactly 1 write occurs; `error`=1, `words_done`=1, `done` pulses, `busy` drops.
  - The next start clears `error`.
- **Auto trigger**: `auto_en`=1, `trig` rises, `count`=5 (irq model).
  - The burst starts 1 cycle after the edge.
  - `trig` toggling during `busy` is ignored.
  - `trig` held high after `done` causes no second burst.
- **Reset mid-burst**: assert `HRESETn`=0 in WR_A.
  - HTRANS=0, `busy`=0 and HADDR=0 immediately (asynchronously).
  - After release, a new start runs a clean burst from ring offset 0.
